jacobian_column_seq: RTL and testbench

- Parametrised sequential Jacobian builder for an NJ-joint chain.
- Processes one joint per pass through a shared 6-multiplier cross-product datapath, time-multiplexing all joints.
- Revolute joint column: linear = axis × (end − joint_pos), angular = axis. Prismatic joint column: linear = axis, angular = 0.
- Sits after the forward-kinematics T-block stage. Streams columns to the update stage and also holds the full matrix.

---
 rtl/jacobian_pkg.sv | 13 +
 rtl/jacobian_column_seq_if.sv | 32 +++
 rtl/jacobian_cross3.sv | 30 +++
 rtl/jacobian_column_seq.sv | 107 ++++++++++
 tb/tb_jacobian_column_seq.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/jacobian_pkg.sv
// jacobian_pkg: shared word sizes, fixed-point types and FSM states for the Jacobian column builder
package jacobian_pkg;
  localparam int W = 27;
  localparam int FRAC = 16;
  typedef logic signed [W-1:0] fix_t;
  typedef fix_t [2:0] vec3_t;
  typedef fix_t [5:0] col_t;
  typedef enum logic [2:0] {IDLE, DIFF, MUL, COMB, FIN} state_t;
  localparam fix_t ONE = fix_t'(1) << FRAC;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/jacobian_column_seq_if.sv
// jacobian_column_seq_if: control, joint inputs and column outputs; vectors pack {x,y,z} as [2:0], columns {lin,ang} as [5:0]
// sat_flag exists only when JACOBIAN_SAT_EN is defined
interface jacobian_column_seq_if #(
  parameter int NJ = 6,
  parameter int W = jacobian_pkg::W
);
  localparam int IW = jacobian_pkg::idx_w(NJ);
  logic en, start, busy, done, col_valid;
  logic [NJ-1:0] joint_type;
  logic [NJ-1:0][2:0][W-1:0] axis, joint_pos;
  logic [2:0][W-1:0] end_pos;
  logic [IW-1:0] col_idx;
  logic [5:0][W-1:0] col_data;
  logic [NJ-1:0][5:0][W-1:0] jacobian_matrix;
`ifdef JACOBIAN_SAT_EN
  logic sat_flag;
`endif
  modport slave (
    input en, start, joint_type, axis, joint_pos, end_pos,
`ifdef JACOBIAN_SAT_EN
    output sat_flag,
`endif
    output busy, done, col_valid, col_idx, col_data, jacobian_matrix
  );
  modport master (
    output en, start, joint_type, axis, joint_pos, end_pos,
`ifdef JACOBIAN_SAT_EN
    input sat_flag,
`endif
    input busy, done, col_valid, col_idx, col_data, jacobian_matrix
  );
endinterface

// File: rtl/jacobian_cross3.sv
// jacobian_cross3: rounds, rescales and reduces the three cross-product differences to W bits
// JACOBIAN_SAT_EN selects clamping with an overflow flag instead of two's-complement wrap
module jacobian_cross3 #(
  parameter int W = jacobian_pkg::W,
  parameter int FRAC = jacobian_pkg::FRAC
) (
  input  logic [5:0][2*W-1:0] prod_i,
`ifdef JACOBIAN_SAT_EN
  output logic                sat_o,
`endif
  output logic [2:0][W-1:0]   res_o
);
  localparam logic signed [2*W:0] RND = (2*W+1)'(1) << (FRAC-1);
`ifdef JACOBIAN_SAT_EN
  logic [2:0] ovf;
  assign sat_o = |ovf;
`endif
  for (genvar k = 0; k < 3; k++) begin : g_lane
    logic signed [2*W:0] df;
    assign df = $signed({prod_i[2*k][2*W-1], prod_i[2*k]}) - $signed({prod_i[2*k+1][2*W-1], prod_i[2*k+1]});
`ifdef JACOBIAN_SAT_EN
    logic signed [2*W:0] sh;
    assign sh = (df + RND) >>> FRAC;
    assign ovf[k] = sh[2*W:W-1] != {(W+2){sh[W-1]}};
    assign res_o[2-k] = !ovf[k] ? sh[W-1:0] : sh[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`else
    assign res_o[2-k] = W'((df + RND) >>> FRAC);
`endif
  end
endmodule

// File: rtl/jacobian_column_seq.sv
// jacobian_column_seq: builds one Jacobian column per 3 cycles through a shared 6-multiplier cross product
// JACOBIAN_SAT_EN adds clamping of out-of-range linear terms and the sticky sat_flag output
module jacobian_column_seq #(
  parameter int NJ = 6,
  parameter int W = jacobian_pkg::W,
  parameter int FRAC = jacobian_pkg::FRAC
) (
  input logic clk,
  input logic rst,
  jacobian_column_seq_if.slave bus
);
  import jacobian_pkg::*;
  localparam int IW = idx_w(NJ);
  state_t state_q;
  logic [IW-1:0] j_q, idx_q;
  logic [2:0][W-1:0] d_q, ax_q, lin;
  logic pr_q, busy_q, done_q, cv_q;
  logic [5:0][2*W-1:0] p_q;
  logic [5:0][W-1:0] col, cd_q;
  logic [NJ-1:0][5:0][W-1:0] mat_q;
  function automatic logic [2*W-1:0] mul(input logic [W-1:0] a, input logic [W-1:0] b);
    return (2*W)'($signed(a)) * (2*W)'($signed(b));
  endfunction
`ifdef JACOBIAN_SAT_EN
  logic sat, sat_q;
  assign bus.sat_flag = sat_q;
`endif
  jacobian_cross3 #(.W(W), .FRAC(FRAC)) u_cross (
`ifdef JACOBIAN_SAT_EN
    .sat_o(sat),
`endif
    .prod_i(p_q),
    .res_o(lin)
  );
  assign col = pr_q ? {ax_q, {(3*W){1'b0}}} : {lin, ax_q};
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.col_valid = cv_q;
  assign bus.col_idx = idx_q;
  assign bus.col_data = cd_q;
  assign bus.jacobian_matrix = mat_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      j_q <= '0;
      d_q <= '0;
      ax_q <= '0;
      pr_q <= 1'b0;
      p_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cv_q <= 1'b0;
      idx_q <= '0;
      cd_q <= '0;
      mat_q <= '0;
`ifdef JACOBIAN_SAT_EN
      sat_q <= 1'b0;
`endif
    end else if (bus.en) begin
      done_q <= 1'b0;
      cv_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          state_q <= DIFF;
          j_q <= '0;
          busy_q <= 1'b1;
`ifdef JACOBIAN_SAT_EN
          sat_q <= 1'b0;
`endif
        end
        DIFF: begin
          for (int k = 0; k < 3; k++) d_q[k] <= bus.end_pos[k] - bus.joint_pos[j_q][k];
          ax_q <= bus.axis[j_q];
          pr_q <= bus.joint_type[j_q];
          state_q <= MUL;
        end
        MUL: begin
          // {ay*dz, az*dy}, {az*dx, ax*dz}, {ax*dy, ay*dx}; vector index 2=x, 1=y, 0=z
          p_q[0] <= mul(ax_q[1], d_q[0]);
          p_q[1] <= mul(ax_q[0], d_q[1]);
          p_q[2] <= mul(ax_q[0], d_q[2]);
          p_q[3] <= mul(ax_q[2], d_q[0]);
          p_q[4] <= mul(ax_q[2], d_q[1]);
          p_q[5] <= mul(ax_q[1], d_q[2]);
          state_q <= COMB;
        end
        COMB: begin
          cv_q <= 1'b1;
          idx_q <= j_q;
          cd_q <= col;
          mat_q[j_q] <= col;
`ifdef JACOBIAN_SAT_EN
          sat_q <= sat_q | (sat & !pr_q);
`endif
          state_q <= j_q == IW'(NJ-1) ? FIN : DIFF;
          j_q <= j_q + IW'(1);
        end
        FIN: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_jacobian_column_seq.sv
// tb_jacobian_column_seq: scoreboard bench for jacobian_column_seq with NJ=6, W=27, FRAC=16
module tb_jacobian_column_seq;
  import jacobian_pkg::*;
  localparam int NJ = 6;
  typedef logic [2:0][W-1:0] vec_v;
  typedef logic [5:0][W-1:0] col_v;
  typedef struct { int idx; col_v col; int lat; } ent_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  jacobian_column_seq_if #(.NJ(NJ), .W(W)) bus ();
  jacobian_column_seq #(.NJ(NJ), .W(W), .FRAC(FRAC)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, s_cyc = 0, done_lat = 0, done_cnt = 0;
  bit last_en = 1'b0;
  bit sat_exp;
  ent_t sb[$];
  ent_t e;
  col_v exp_mat[NJ];
  col_v ca;

  task automatic check(string tag, logic [255:0] got, logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_v v3(longint x, longint y, longint z);
    return {W'(x), W'(y), W'(z)};
  endfunction

  function automatic col_v model(vec_v a, vec_v d, bit pr, output bit s);
    longint ax = $signed(a[2]), ay = $signed(a[1]), az = $signed(a[0]);
    longint dx = $signed(d[2]), dy = $signed(d[1]), dz = $signed(d[0]);
    longint mx = (longint'(1) << (W-1)) - 1, mn = -(longint'(1) << (W-1));
    longint v[3];
    longint r;
    col_v c;
    v[0] = ay*dz - az*dy;
    v[1] = az*dx - ax*dz;
    v[2] = ax*dy - ay*dx;
    s = 1'b0;
    for (int k = 0; k < 3; k++) begin
      r = (v[k] + (longint'(1) << (FRAC-1))) >>> FRAC;
`ifdef JACOBIAN_SAT_EN
      if (r > mx) begin r = mx; s = 1'b1; end
      else if (r < mn) begin r = mn; s = 1'b1; end
`endif
      c[5-k] = r[W-1:0];
    end
    c[2:0] = a;
    if (pr) begin
      c[5:3] = a;
      c[2:0] = '0;
      s = 1'b0;
    end
    return c;
  endfunction

  task automatic set_joint(int j, vec_v ax, vec_v d, bit pr);
    bus.axis[j] = ax;
    bus.joint_type[j] = pr;
    for (int k = 0; k < 3; k++) bus.joint_pos[j][k] = bus.end_pos[k] - d[k];
  endtask

  task automatic prep(bit lat_on);
    bit s;
    vec_v d;
    sat_exp = 1'b0;
    for (int j = 0; j < NJ; j++) begin
      for (int k = 0; k < 3; k++) d[k] = bus.end_pos[k] - bus.joint_pos[j][k];
      exp_mat[j] = model(bus.axis[j], d, bus.joint_type[j], s);
      sat_exp |= s;
      sb.push_back('{j, exp_mat[j], lat_on ? 3*(j+1) : -1});
    end
  endtask

  task automatic kick(bit imm);
    if (!imm) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    s_cyc = cyc;
    check("busy_on", bus.busy, 1);
`ifdef JACOBIAN_SAT_EN
    check("sat_clr", bus.sat_flag, 0);
`endif
  endtask

  task automatic wait_done(int n0);
    int t = 0;
    while (done_cnt == n0 && t < 100) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("done_seen", done_cnt, n0 + 1);
  endtask

  task automatic run_pass(bit lat_on, int stall_at, int busy_start_at, bit imm);
    int n0 = done_cnt;
    logic [255:0] snap[4];
    prep(lat_on);
    done_lat = 3*NJ + 1 + (stall_at > 0 ? 5 : 0);
    kick(imm);
    if (busy_start_at > 0) begin
      repeat (busy_start_at) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    if (stall_at > 0) begin
      repeat (stall_at) @(negedge clk);
      bus.en = 1'b0;
      snap = '{256'(bus.busy), 256'(bus.col_valid), 256'(bus.col_idx), 256'(bus.col_data)};
      repeat (5) begin
        @(negedge clk);
        check("stall_busy", bus.busy, snap[0]);
        check("stall_cv", bus.col_valid, snap[1]);
        check("stall_idx", bus.col_idx, snap[2]);
        check("stall_data", bus.col_data, snap[3]);
      end
      bus.en = 1'b1;
    end
    wait_done(n0);
    check("busy_off", bus.busy, 0);
    check("sb_empty", sb.size(), 0);
    for (int j = 0; j < NJ; j++) check($sformatf("mat%0d", j), bus.jacobian_matrix[j], exp_mat[j]);
`ifdef JACOBIAN_SAT_EN
    check("sat", bus.sat_flag, sat_exp);
`endif
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    last_en <= bus.en;
  end

  // only outputs produced by an enabled edge are new; held values during en low are not recounted
  always @(negedge clk) if (last_en && !rst) begin
    if (bus.col_valid) begin
      if (sb.size() == 0) check("col_extra", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("col_idx", bus.col_idx, e.idx);
        check($sformatf("col%0d", e.idx), bus.col_data, e.col);
        if (e.lat >= 0) check("col_lat", cyc - s_cyc, e.lat);
      end
    end
    if (bus.done) begin
      done_cnt++;
      check("done_lat", cyc - s_cyc, done_lat);
    end
  end

  initial begin
    int n0;
    bus.en = 1'b1;
    bus.start = 1'b0;
    bus.end_pos = v3(ONE, 0, 0);
    for (int j = 0; j < NJ; j++) set_joint(j, v3(0, 0, ONE), v3(ONE, 0, 0), 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_cv", bus.col_valid, 0);
    check("rst_idx", bus.col_idx, 0);
    check("rst_data", bus.col_data, 0);
    check("rst_mat", |bus.jacobian_matrix, 0);
    ca = {W'(0), ONE, W'(0), W'(0), W'(0), ONE};
    run_pass(1'b1, 0, 0, 1'b0);
    check("A_col3", bus.jacobian_matrix[3], ca);
    set_joint(2, v3(ONE, 0, 0), v3(ONE, 0, 0), 1'b1);
    run_pass(1'b1, 0, 4, 1'b0);
    check("B_pris", bus.jacobian_matrix[2], {ONE, W'(0), W'(0), W'(0), W'(0), W'(0)});
    check("B_col1", bus.jacobian_matrix[1], ca);
    set_joint(0, v3(0, 0, 1), v3(3, 0, 0), 1'b0);
    set_joint(1, v3(0, 0, ONE), v3(32'h8000, 0, 0), 1'b0);
    set_joint(2, v3(0, 0, 1), v3(32'h8000, 0, 0), 1'b0);
    set_joint(3, v3(0, 0, 1), v3(-32'sh8000, 0, 0), 1'b0);
    set_joint(4, v3(0, 0, 32'h3FFFFFF), v3(32'h3FFFFFF, 0, 0), 1'b0);
    set_joint(5, v3(0, 0, 32'h3FFFFFF), v3(-32'sh4000000, 0, 0), 1'b0);
    run_pass(1'b1, 0, 0, 1'b0);
    check("rnd_3lsb", bus.jacobian_matrix[0][4], 0);
    check("rnd_exact", bus.jacobian_matrix[1][4], 27'h8000);
    check("rnd_half", bus.jacobian_matrix[2][4], 1);
    check("rnd_nhalf", bus.jacobian_matrix[3][4], 0);
`ifdef JACOBIAN_SAT_EN
    check("ovf_pos", bus.jacobian_matrix[4][4], 27'h3FFFFFF);
    check("ovf_neg", bus.jacobian_matrix[5][4], 27'h4000000);
    check("sat_set", bus.sat_flag, 1);
`else
    check("ovf_pos", bus.jacobian_matrix[4][4], 27'h7FFF800);
    check("ovf_neg", bus.jacobian_matrix[5][4], 27'h400);
`endif
    bus.end_pos = v3($urandom, $urandom, $urandom);
    for (int j = 0; j < NJ; j++) set_joint(j, v3($urandom, $urandom, $urandom), v3($urandom, $urandom, $urandom), 1'($urandom));
    run_pass(1'b0, 6, 0, 1'b0);
    run_pass(1'b1, 0, 0, 1'b1);
    n0 = done_cnt;
    prep(1'b1);
    done_lat = 3*NJ + 1;
    kick(1'b0);
    repeat (6) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    #1 rst = 1'b0;
    sb.delete();
    check("mid_busy", bus.busy, 0);
    check("mid_cv", bus.col_valid, 0);
    check("mid_mat", |bus.jacobian_matrix, 0);
    repeat (30) @(negedge clk);
    check("mid_nodone", done_cnt, n0);
    check("mid_idle", bus.busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
